// File: rtl/rs232_receiver.sv
// 8N1 serial receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// level-valid output register with acknowledge, framing error and overrun flags.
module rs232_receiver #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun
);

    localparam int unsigned BitClks  = CLK_FREQ / BAUD;
    localparam int unsigned HalfClks = (BitClks / 2 > 0) ? BitClks / 2 : 1;
    localparam int unsigned CntW     = (BitClks > 2) ? $clog2(BitClks) : 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(BitClks - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfClks - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            fe_q;
    logic            ovr_q;
    logic            rx_meta_q;
    logic            rxs_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame FSM plus output register, acknowledge and error flag handling.
    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            // Acknowledge clears; a good frame in the same cycle overrides below.
            if (data_ack && valid_q) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rxs_q) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q <= rxs_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs_q;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            state_q <= StIdle;
                            if (!valid_q || data_ack) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= StWaitIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitIdle: begin
                    cnt_q <= '0;
                    if (rxs_q) state_q <= StIdle;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign busy        = (state_q != StIdle);
    assign framing_err = fe_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver at default 50 MHz / 115200 baud.
module tb_rs232_receiver;

    localparam int unsigned B = 50000000 / 115200;
    localparam int unsigned H = B / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic       framing_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int dv_rise_cyc = 0;
    int dv_rises = 0;
    int fe_pulses = 0;
    int fe_run = 0;
    int fe_max = 0;
    logic dv_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    rs232_receiver dut (
        .CLK50MHZ   (clk),
        .RST        (rst),
        .RxD        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture delivered bytes and measure framing_err pulses.
    always @(negedge clk) begin
        if (data_valid && !dv_prev) begin
            dv_rises++;
            dv_rise_cyc = cyc;
            got_q.push_back(data);
        end
        dv_prev = data_valid;
        if (framing_err) begin
            fe_run++;
        end else if (fe_run > 0) begin
            fe_pulses++;
            if (fe_run > fe_max) fe_max = fe_run;
            fe_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (B) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!data_valid && n < max) begin
            tick();
            n++;
        end
        check(tag, {31'd0, data_valid}, 32'd1);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        tick();
    endtask

    task automatic sb_pop(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        check({tag, "_avail"}, {31'd0, (got_q.size() != 0 && exp_q.size() != 0)}, 32'd1);
        if (got_q.size() != 0 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check(tag, {24'd0, g}, {24'd0, e});
        end
    endtask

    initial begin
        int lat;
        int fe_base;
        int dv_base;

        // Reset state
        repeat (4) tick();
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fe", {31'd0, framing_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        repeat (4) tick();

        // Good frame 0xA5 and its latency from the start-bit edge
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid("a5_valid", 2 * B);
        sb_pop("a5_data");
        lat = dv_rise_cyc - start_cyc;
        // Nominal H+9B+4 +/-1, widened by the half cycle between drive and edge.
        check("a5_latency", {31'd0, (lat >= int'(H + 9 * B + 2) && lat <= int'(H + 9 * B + 5))},
              32'd1);
        check("a5_no_fe", fe_pulses + fe_run, 32'd0);
        ack_pulse();
        check("a5_ack_clr", {31'd0, data_valid}, 32'd0);
        check("a5_data_hold", {24'd0, data}, 32'hA5);

        // Bad stop bit on 0x3C: one-cycle error, no delivery, busy until line high
        fe_base = fe_pulses;
        dv_base = dv_rises;
        send_frame(8'h3C, 1'b0);
        repeat (B) tick();
        check("fe_count", fe_pulses - fe_base, 32'd1);
        check("fe_width", fe_max, 32'd1);
        check("fe_busy_low", {31'd0, busy}, 32'd1);
        check("fe_no_valid", {31'd0, data_valid}, 32'd0);
        rxd = 1'b1;
        repeat (5) tick();
        check("fe_busy_clr", {31'd0, busy}, 32'd0);
        check("fe_no_delivery", dv_rises - dv_base, 32'd0);

        // 100-cycle glitch rejected at mid start bit
        fe_base = fe_pulses;
        rxd = 1'b0;
        repeat (50) tick();
        check("gl_busy", {31'd0, busy}, 32'd1);
        repeat (50) tick();
        rxd = 1'b1;
        repeat (H + 10) tick();
        check("gl_idle", {31'd0, busy}, 32'd0);
        check("gl_no_valid", {31'd0, data_valid}, 32'd0);
        check("gl_no_fe", fe_pulses - fe_base, 32'd0);
        check("gl_no_delivery", dv_rises - dv_base, 32'd0);

        // Overrun: 0x11 held unacknowledged, 0x22 dropped
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_valid("ov_valid1", 2 * B);
        send_frame(8'h22, 1'b1);
        repeat (4) tick();
        check("ov_flag", {31'd0, overrun}, 32'd1);
        check("ov_data_kept", {24'd0, data}, 32'h11);
        sb_pop("ov_sb");
        check("ov_one_delivery", got_q.size(), 32'd0);
        ack_pulse();
        check("ov_ack_valid", {31'd0, data_valid}, 32'd0);
        check("ov_ack_flag", {31'd0, overrun}, 32'd0);

        // Reset during bit 4 of 0xFF, then 0x5A
        fe_base = fe_pulses;
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (H) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mr_data", {24'd0, data}, 32'h00);
        check("mr_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (B) tick();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_valid("mr_valid", 2 * B);
        sb_pop("mr_sb");
        check("mr_only_one", got_q.size(), 32'd0);
        check("mr_no_fe", fe_pulses - fe_base, 32'd0);
        ack_pulse();

        // Back-to-back frames with an acknowledge on each valid
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h55, 1'b1);
                rxd = 1'b1;
                repeat (B) tick();
            end
            begin
                repeat (32 * B) begin
                    tick();
                    data_ack = data_valid && !data_ack;
                end
            end
        join
        data_ack = 1'b0;
        tick();
        sb_pop("bb_0");
        sb_pop("bb_1");
        sb_pop("bb_2");
        check("bb_ovr", {31'd0, overrun}, 32'd0);
        check("bb_valid_clr", {31'd0, data_valid}, 32'd0);
        check("bb_no_extra", got_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_receiver.md
RS232_RECEIVER -- requirements
Module: rs232_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port CLK50MHZ  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-low (RST=0 resets on next clock edge).
REQ-005 SHALL have port RxD  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port data  output  8  last received byte.
REQ-007 SHALL have port data_valid  output  1  level, high while an unacknowledged byte is held in data.
REQ-008 SHALL have port data_ack  input  1  consumer acknowledge, sampled each clock.
REQ-009 SHALL have port busy  output  1  high while a frame is being received (any state except IDLE).
REQ-010 SHALL have port framing_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky flag, a byte completed while data_valid was high.

Function
REQ-012 SHALL derive BIT_CLKS = CLK_FREQ/BAUD (integer truncation; 434 at defaults) and HALF_CLKS = BIT_CLKS/2 (217).
REQ-013 SHALL pass RxD through a 2-flop synchronizer; all decisions use the synchronized value rxs; synchronizer flops reset to 1.
REQ-014 SHALL use a baud counter wide enough for BIT_CLKS-1, cleared on every state entry.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: on rxs=0 go to START; otherwise remain.
REQ-017 START: after HALF_CLKS cycles, sample rxs; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no output change).
REQ-018 DATA: every BIT_CLKS cycles sample rxs into shift register bit[index]; after index 7 go to STOP.
REQ-019 STOP: after BIT_CLKS cycles sample rxs; 1 -> frame good, go to IDLE; 0 -> framing_err pulse, byte discarded, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until rxs=1, then IDLE; no start detection while here.
REQ-021 On good frame with data_valid=0: data <= shift register and data_valid <= 1 on the cycle after the stop-bit sample.
REQ-022 On good frame with data_valid=1 and data_ack=0 on that cycle: data unchanged, new byte dropped, overrun <= 1.
REQ-023 On good frame in the same cycle as data_ack=1 with data_valid=1: new byte loaded, data_valid stays 1, no overrun.
REQ-024 data_ack=1 with data_valid=1 SHALL clear data_valid and overrun on the next edge; data_ack with data_valid=0 SHALL be ignored.
REQ-025 data SHALL hold its value after acknowledge until the next good frame.
REQ-026 RxD-to-data_valid latency for a frame SHALL be 2 (sync) + 1 (IDLE detect) + HALF_CLKS + 9*BIT_CLKS + 1 cycles from the start-bit falling edge, +/-1 cycle.

Reset
REQ-027 With RST=0 at a clock edge: state IDLE, counters 0, data=8'h00, data_valid=0, busy=0, framing_err=0, overrun=0, synchronizer=1.
REQ-028 Reset mid-frame SHALL abort the frame with no data_valid or framing_err; after release a line held low SHALL be treated as a new start bit.

Verification
REQ-029 Send 8'hA5 at 115200 with proper stop bit -> data=8'hA5, data_valid=1 within REQ-026 latency, framing_err never high.
REQ-030 Send 8'h3C, hold stop bit low -> framing_err one-cycle pulse, data_valid stays 0, busy stays high until RxD returns high.
REQ-031 Drive RxD low for 100 cycles then high -> START rejects the glitch, returns to IDLE, no outputs change.
REQ-032 Send 8'h11 without ack, then 8'h22 -> data=8'h11, overrun=1; pulse data_ack -> data_valid=0, overrun=0.
REQ-033 Assert RST=0 during bit 4 of 8'hFF, release, send 8'h5A -> only 8'h5A delivered, no framing_err.
REQ-034 Back-to-back frames 8'h00, 8'hFF, 8'h55 with ack pulsed on each data_valid -> all three delivered in order, overrun=0.
